// File: rtl/sim_ctrl_regs.sv
// Simulation control registers: firmware exit code, VCD dump trigger and an optional cycle timer.
// The timer (FSM, counter, completed-interval count, busy flag) is built only when SIM_CTRL_TIMER_EN is defined.
module sim_ctrl_regs #(
    parameter int unsigned TIMER_W = 32
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [4:0]  addr_i,
    input  logic [31:0] wdata_i,
    output logic        gnt_o,
    output logic        rvalid_o,
    output logic [31:0] rdata_o,
    output logic        err_o,
    output logic        exit_valid_o,
    output logic [31:0] exit_value_o,
    output logic        vcd_trigger_o,
    output logic        timer_busy_o
);

    localparam logic [2:0] REG_EXIT  = 3'd0;
    localparam logic [2:0] REG_VCD   = 3'd1;
    localparam logic [2:0] REG_TCTRL = 3'd2;
    localparam logic [2:0] REG_TCNT  = 3'd3;
    localparam logic [2:0] REG_TRUNS = 3'd4;

    if (TIMER_W < 8 || TIMER_W > 32) begin : g_bad_timer_w
        $error("sim_ctrl_regs: TIMER_W must lie in 8..32");
    end

    logic [2:0]  reg_sel;
    logic        addr_lsb_unused;
    logic        mapped;
    logic        read_only;
    logic        acc_err;
    logic        wr_ok;
    logic        exit_we;
    logic        vcd_we;
    logic [31:0] rdata_d;
    logic [31:0] tctrl_rd;
    logic [31:0] tcnt_rd;
    logic [31:0] truns_rd;

    // The bus grants every request immediately; the response follows one edge later.
    assign gnt_o           = req_i;
    assign reg_sel         = addr_i[4:2];
    assign addr_lsb_unused = ^addr_i[1:0];

    assign mapped    = (reg_sel <= REG_TRUNS);
    assign read_only = (reg_sel == REG_TCNT) || (reg_sel == REG_TRUNS);
    assign acc_err   = !mapped || (we_i && read_only);
    assign wr_ok     = req_i && we_i && !acc_err;
    assign exit_we   = wr_ok && (reg_sel == REG_EXIT) && !exit_valid_o;
    assign vcd_we    = wr_ok && (reg_sel == REG_VCD);

    // NOTE: every signal written in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        rdata_d = '0;
        if (req_i && !we_i && !acc_err) begin
            case (reg_sel)
                REG_VCD:   rdata_d = {31'b0, vcd_trigger_o};
                REG_TCTRL: rdata_d = tctrl_rd;
                REG_TCNT:  rdata_d = tcnt_rd;
                REG_TRUNS: rdata_d = truns_rd;
                default:   rdata_d = '0;
            endcase
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            rvalid_o <= 1'b0;
            rdata_o  <= '0;
            err_o    <= 1'b0;
        end else begin
            rvalid_o <= req_i;
            rdata_o  <= rdata_d;
            err_o    <= req_i && acc_err;
        end
    end

    // Exit code is captured once and held until reset; later writes are silently dropped.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            exit_valid_o  <= 1'b0;
            exit_value_o  <= '0;
            vcd_trigger_o <= 1'b0;
        end else begin
            if (exit_we) begin
                exit_valid_o <= 1'b1;
                exit_value_o <= wdata_i;
            end
            if (vcd_we) begin
                vcd_trigger_o <= wdata_i[0];
            end
        end
    end

`ifdef SIM_CTRL_TIMER_EN
    typedef enum logic [1:0] {
        T_IDLE = 2'd0,
        T_RUN  = 2'd1,
        T_DONE = 2'd2
    } timer_state_t;

    timer_state_t       state_q;
    timer_state_t       state_d;
    logic [TIMER_W-1:0] cnt_q;
    logic [TIMER_W-1:0] cnt_d;
    logic [15:0]        runs_q;
    logic [15:0]        runs_d;
    logic               tctrl_we;
    logic               start_cmd;
    logic               stop_cmd;

    // Start and stop together cancel out and are accepted as a no-op.
    assign tctrl_we  = wr_ok && (reg_sel == REG_TCTRL);
    assign start_cmd = tctrl_we && (wdata_i[1:0] == 2'b01);
    assign stop_cmd  = tctrl_we && (wdata_i[1:0] == 2'b10);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        runs_d  = runs_q;
        case (state_q)
            T_RUN: begin
                cnt_d = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
                if (start_cmd) begin
                    cnt_d = '0;
                end else if (stop_cmd) begin
                    state_d = T_DONE;
                    runs_d  = runs_q + 16'd1;
                end
            end
            default: begin
                if (start_cmd) begin
                    cnt_d   = '0;
                    state_d = T_RUN;
                end
            end
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= T_IDLE;
            cnt_q   <= '0;
            runs_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            runs_q  <= runs_d;
        end
    end

    assign timer_busy_o = (state_q == T_RUN);
    assign tctrl_rd     = {30'b0, state_q == T_DONE, state_q == T_RUN};
    assign tcnt_rd      = 32'(cnt_q);
    assign truns_rd     = {16'b0, runs_q};
`else
    assign timer_busy_o = 1'b0;
    assign tctrl_rd     = '0;
    assign tcnt_rd      = '0;
    assign truns_rd     = '0;
`endif

endmodule

// File: doc/sim_ctrl_regs.md
SIM_CTRL_REGS -- requirements
Module: sim_ctrl_regs

Interface
REQ-001 SHALL have parameter TIMER_W, default 32, meaning width of the cycle timer counter (legal range 8..32).
REQ-002 SHALL have sys_clk  input  1  system clock; all state updates on rising edge.
REQ-003 SHALL have sys_rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have req_i  input  1  bus request.
REQ-005 SHALL have we_i  input  1  write enable, qualified by req_i.
REQ-006 SHALL have addr_i  input  5  byte address; bits [1:0] are ignored.
REQ-007 SHALL have wdata_i  input  32  write data.
REQ-008 SHALL have gnt_o  output  1  grant; equals req_i combinationally.
REQ-009 SHALL have rvalid_o  output  1  response valid, one cycle after grant.
REQ-010 SHALL have rdata_o  output  32  read data, valid with rvalid_o.
REQ-011 SHALL have err_o  output  1  unmapped-address flag, valid with rvalid_o.
REQ-012 SHALL have exit_valid_o  output  1  sticky end-of-test flag, consumed by the testbench exit monitor.
REQ-013 SHALL have exit_value_o  output  32  firmware return code.
REQ-014 SHALL have vcd_trigger_o  output  1  waveform dump trigger level.
REQ-015 SHALL have timer_busy_o  output  1  high while the timer is in RUN.

Function
REQ-016 SHALL decode the register map: 0x00 EXIT (W), 0x04 VCD (RW, bit0), 0x08 TCTRL (W: bit0 start, bit1 stop; read returns {30'b0, state==DONE, state==RUN}), 0x0C TCNT (R, zero-extended counter), 0x10 TRUNS (R, 16-bit completed-interval count, zero-extended).
REQ-017 SHALL assert rvalid_o exactly one cycle after every granted request, reads and writes alike; rdata_o SHALL be 0 on writes.
REQ-018 SHALL, for an unmapped address or a write to a read-only register, set err_o with rvalid_o, return rdata_o=0 and change no state.
REQ-019 SHALL, on a write to EXIT, load exit_value_o with wdata_i and set exit_valid_o in the same edge; both SHALL then hold until reset, and later EXIT writes SHALL be ignored without error.
REQ-020 SHALL drive vcd_trigger_o from VCD bit0, updated on the write edge.
REQ-021 SHALL implement timer FSM states IDLE, RUN, DONE.
REQ-022 SHALL, on start in IDLE or DONE, clear the counter and enter RUN.
REQ-023 SHALL, on start in RUN, clear the counter and stay in RUN; TRUNS SHALL not increment.
REQ-024 SHALL, on stop in RUN, freeze the counter, enter DONE and increment TRUNS, which wraps 0xFFFF->0.
REQ-025 SHALL ignore stop in IDLE or DONE.
REQ-026 SHALL treat a TCTRL write with both bit0 and bit1 set as a no-op, without error.
REQ-027 SHALL increment the counter by 1 on every cycle in RUN, including the start edge's following cycle (start write at edge N gives count 1 after edge N+1).
REQ-028 SHALL saturate the counter at 2^TIMER_W-1.

Reset
REQ-029 SHALL, while sys_rst_n is low, force these outputs to 0: rvalid_o, rdata_o, err_o, exit_valid_o, exit_value_o, vcd_trigger_o and timer_busy_o.
REQ-030 SHALL, while sys_rst_n is low, force the counter and TRUNS to 0 and the FSM to IDLE.
REQ-031 SHALL, on reset assertion mid-interval, abort the interval without incrementing TRUNS.

Configuration
REQ-032 SHALL, when macro SIM_CTRL_TIMER_EN is defined, include the timer FSM, counter, TRUNS and timer_busy_o logic.
REQ-033 SHALL, when SIM_CTRL_TIMER_EN is undefined, read TCTRL, TCNT and TRUNS as 0 without error, ignore TCTRL writes without error, and tie timer_busy_o to 0.

Verification
REQ-034 SHALL cover: write EXIT=0x0000002A -> next edge exit_valid_o=1, exit_value_o=42; then write EXIT=5 -> exit_value_o stays 42.
REQ-035 SHALL cover: write TCTRL=1, idle 99 cycles, write TCTRL=2 -> TCNT reads 100, TRUNS=1, TCTRL reads 0x2.
REQ-036 SHALL cover: start, 10 cycles, start again, 20 cycles, stop -> TCNT=21, TRUNS=1.
REQ-037 SHALL cover: TIMER_W=8, run 300 cycles -> TCNT=255; TCTRL=3 in RUN -> state unchanged, err_o=0.
REQ-038 SHALL cover: read 0x14 -> err_o=1, rdata_o=0; sys_rst_n pulse low during RUN -> TCNT=0, TRUNS=0, timer_busy_o=0.
REQ-039 SHALL cover, with SIM_CTRL_TIMER_EN undefined: write TCTRL=1 -> timer_busy_o=0, TCNT reads 0.
